// File: rtl/dds_pwm_amplitude_gen_pkg.sv
// Shared definitions for the DDS amplitude PWM generator.
//   PWM_MAX_F        : last counter value for a given width (period = MAX+1 ticks)
//   Default*         : default parameter values for WIDTH / PRESCALE / DEADTIME
//   pwm_side_t       : output side selected by the dead-time stage
// The optional complementary output is enabled by defining DDS_PWM_COMPLEMENT_EN.
package dds_pwm_pkg;

  localparam int unsigned DefaultWidth    = 16;
  localparam int unsigned DefaultPrescale = 1;
  localparam int unsigned DefaultDeadtime = 4;

  // Counter runs 0..2^width-2 so a full-scale duty word keeps the output high.
  function automatic logic [63:0] PWM_MAX_F(input int unsigned width);
    return (64'd1 << width) - 64'd2;
  endfunction

  typedef enum logic [1:0] {
    SIDE_OFF,
    SIDE_HIGH,
    SIDE_LOW
  } pwm_side_t;

endpackage

// File: rtl/dds_pwm_amplitude_gen_if.sv
// Bus between the amplitude PIO side (master) and the PWM generator (slave).
//   enable       : run PWM, low = idle
//   amplitude    : requested duty word
//   pwm_out      : PWM output (high side when DDS_PWM_COMPLEMENT_EN is defined)
//   period_start : one-cycle pulse at each period start
//   duty_active  : duty word currently applied
//   pwm_l        : complementary low side (only with DDS_PWM_COMPLEMENT_EN)
interface dds_pwm_amplitude_gen_if
  import dds_pwm_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             enable;
  logic [WIDTH-1:0] amplitude;
  logic             pwm_out;
  logic             period_start;
  logic [WIDTH-1:0] duty_active;
`ifdef DDS_PWM_COMPLEMENT_EN
  logic             pwm_l;

  modport master (
    output enable, amplitude,
    input  pwm_out, period_start, duty_active, pwm_l
  );

  modport slave (
    input  enable, amplitude,
    output pwm_out, period_start, duty_active, pwm_l
  );
`else
  modport master (
    output enable, amplitude,
    input  pwm_out, period_start, duty_active
  );

  modport slave (
    input  enable, amplitude,
    output pwm_out, period_start, duty_active
  );
`endif

endinterface

// File: rtl/dds_pwm_deadtime.sv
// Dead-time stage for the complementary PWM outputs (used with DDS_PWM_COMPLEMENT_EN).
//   clk, reset_n : clock, asynchronous active-low reset
//   en_i         : generator enabled; low forces both sides off
//   r_i          : raw registered compare result
//   high_o       : high-side drive (r_i == 1 side)
//   low_o        : low-side drive (r_i == 0 side)
// Any change of r_i turns both sides off for DEADTIME clocks; a further change during
// that window restarts the count, so only a stable r_i is ever driven.
module dds_pwm_deadtime
  import dds_pwm_pkg::*;
#(
  parameter int unsigned DEADTIME = DefaultDeadtime
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic r_i,
  output logic high_o,
  output logic low_o
);

  localparam int unsigned DtW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  pwm_side_t      side_q, side_d;
  logic [DtW-1:0] dt_q, dt_d;
  logic           r_last_q, r_last_d;

  always_comb begin
    side_d   = side_q;
    dt_d     = dt_q;
    r_last_d = r_i;
    if (!en_i) begin
      side_d   = SIDE_OFF;
      dt_d     = '0;
      r_last_d = 1'b0;
    end else if (r_i != r_last_q) begin
      side_d = SIDE_OFF;
      dt_d   = DtW'(DEADTIME);
    end else if (dt_q != '0) begin
      dt_d   = dt_q - 1'b1;
      // Assert the new side on the clock the dead-time window expires.
      side_d = (dt_d == '0) ? (r_i ? SIDE_HIGH : SIDE_LOW) : SIDE_OFF;
    end else begin
      side_d = r_i ? SIDE_HIGH : SIDE_LOW;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      side_q   <= SIDE_OFF;
      dt_q     <= '0;
      r_last_q <= 1'b0;
    end else begin
      side_q   <= side_d;
      dt_q     <= dt_d;
      r_last_q <= r_last_d;
    end
  end

  // One-hot by construction of the enum, so the sides can never overlap.
  assign high_o = (side_q == SIDE_HIGH);
  assign low_o  = (side_q == SIDE_LOW);

endmodule

// File: rtl/dds_pwm_amplitude_gen.sv
// DDS amplitude PWM generator: turns the PIO amplitude word into a registered PWM
// waveform whose high time per period equals the applied duty word.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : enable, amplitude in; pwm_out, period_start, duty_active
//                  (and pwm_l with DDS_PWM_COMPLEMENT_EN) out
// The duty word is shadowed and only reloaded at a period boundary (or while idle),
// so software writes never produce a glitched period. Defining DDS_PWM_COMPLEMENT_EN
// adds a dead-time protected complementary output pair.
module dds_pwm_amplitude_gen
  import dds_pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned PRESCALE = DefaultPrescale,
  parameter int unsigned DEADTIME = DefaultDeadtime
) (
  input  logic                    clk,
  input  logic                    reset_n,
  dds_pwm_amplitude_gen_if.slave  bus
);

  localparam int unsigned      PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0]  PreLast = PreW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CntMax  = WIDTH'(PWM_MAX_F(WIDTH));

  logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_raw_q, pwm_raw_d;
  logic             period_start_q, period_start_d;
  logic             enable_q, enable_d;
  logic             tick;
  logic             wrap;

  always_comb begin
    tick           = (pre_cnt_q == PreLast);
    wrap           = tick && (cnt_q == CntMax);
    pre_cnt_d      = pre_cnt_q;
    cnt_d          = cnt_q;
    duty_d         = duty_q;
    period_start_d = 1'b0;
    pwm_raw_d      = bus.enable & (cnt_q < duty_q);
    enable_d       = bus.enable;
    if (!bus.enable) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
      duty_d    = bus.amplitude;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (tick) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
      // First enabled clock opens a period just like a wrap does.
      if (wrap || !enable_q) begin
        duty_d         = bus.amplitude;
        period_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      pwm_raw_q      <= 1'b0;
      period_start_q <= 1'b0;
      enable_q       <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pwm_raw_q      <= pwm_raw_d;
      period_start_q <= period_start_d;
      enable_q       <= enable_d;
    end
  end

  assign bus.period_start = period_start_q;
  assign bus.duty_active  = duty_q;

`ifdef DDS_PWM_COMPLEMENT_EN
  dds_pwm_deadtime #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (bus.enable),
    .r_i     (pwm_raw_q),
    .high_o  (bus.pwm_out),
    .low_o   (bus.pwm_l)
  );
`else
  logic unused_deadtime;
  assign unused_deadtime = |DEADTIME;
  assign bus.pwm_out     = pwm_raw_q;
`endif

endmodule

// File: tb/tb_dds_pwm_amplitude_gen.sv
// Randomized bench for dds_pwm_amplitude_gen: two instances (PRESCALE 1 and 3, WIDTH 4)
// share the same stimulus and are compared every clock against a time-based model.
module tb_dds_pwm_amplitude_gen;

  localparam int unsigned W      = 4;
  localparam int unsigned Dt     = 2;
  localparam int          Period = 15;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic [W-1:0] amp;

  always #5 clk = ~clk;

  dds_pwm_amplitude_gen_if #(.WIDTH(W)) bus_p1 ();
  dds_pwm_amplitude_gen_if #(.WIDTH(W)) bus_p3 ();

  assign bus_p1.enable    = en;
  assign bus_p1.amplitude = amp;
  assign bus_p3.enable    = en;
  assign bus_p3.amplitude = amp;

  dds_pwm_amplitude_gen #(.WIDTH(W), .PRESCALE(1), .DEADTIME(Dt)) u_dut_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_p1.slave)
  );

  dds_pwm_amplitude_gen #(.WIDTH(W), .PRESCALE(3), .DEADTIME(Dt)) u_dut_p3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_p3.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state per instance (0: PRESCALE=1, 1: PRESCALE=3).
  int pre [2] = '{1, 3};
  int m_n [2];           // consecutive enabled edges so far
  int m_duty [2];
  bit m_start [2];
  bit m_raw [2];
  bit m_hi [2];
  bit m_lo [2];
  bit rh [2][Dt+1];      // recent visible raw compare values, [0] newest
  int win_len [2];
  int win_hi [2];
  int win_duty [2];
  bit win_valid [2];
  bit win_active [2];

  // Expected outputs after one clock edge, derived from elapsed enabled time.
  task automatic model_edge(input int k);
    int p;
    int cnt_before;
    bit all_eq;
    p      = pre[k];
    all_eq = 1'b1;
    for (int i = 1; i <= Dt; i++) if (rh[k][i] != rh[k][0]) all_eq = 1'b0;
    if (!en) begin
      m_n[k]     = 0;
      m_duty[k]  = int'(amp);
      m_start[k] = 1'b0;
      m_raw[k]   = 1'b0;
      m_hi[k]    = 1'b0;
      m_lo[k]    = 1'b0;
    end else begin
      m_n[k]++;
      cnt_before = ((m_n[k] - 1) / p) % Period;
      m_raw[k]   = (cnt_before < m_duty[k]);
      m_start[k] = (m_n[k] == 1) || (m_n[k] % (Period * p) == 0);
      if (m_start[k]) m_duty[k] = int'(amp);
      m_hi[k] = all_eq && rh[k][0];
      m_lo[k] = all_eq && !rh[k][0];
    end
    for (int i = Dt; i >= 1; i--) rh[k][i] = rh[k][i-1];
    rh[k][0] = m_raw[k];
  endtask

  task automatic compare(input int k);
    logic         ps, po, pl;
    logic [W-1:0] da;
    string        t;
    t  = (k == 0) ? "p1" : "p3";
    ps = (k == 0) ? bus_p1.period_start : bus_p3.period_start;
    po = (k == 0) ? bus_p1.pwm_out : bus_p3.pwm_out;
    da = (k == 0) ? bus_p1.duty_active : bus_p3.duty_active;
    pl = 1'b0;
    check_eq({t, " period_start"}, 32'(ps), 32'(m_start[k]));
    check_eq({t, " duty_active"}, 32'(da), 32'(m_duty[k]));
`ifdef DDS_PWM_COMPLEMENT_EN
    pl = (k == 0) ? bus_p1.pwm_l : bus_p3.pwm_l;
    check_eq({t, " pwm_out"}, 32'(po), 32'(m_hi[k]));
    check_eq({t, " pwm_l"}, 32'(pl), 32'(m_lo[k]));
    check_eq({t, " both_high"}, 32'(po & pl), 32'd0);
`else
    check_eq({t, " pwm_out"}, 32'(po), 32'(m_raw[k]));
`endif
    // Whole-period checks on the observed waveform: window opens the clock after a
    // period_start pulse and closes on the next pulse.
    if (win_active[k]) begin
      win_len[k]++;
      win_hi[k] += int'(po);
    end
    if (ps) begin
      if (win_valid[k]) begin
        check_eq({t, " period_len"}, 32'(win_len[k]), 32'(Period * pre[k]));
`ifndef DDS_PWM_COMPLEMENT_EN
        check_eq({t, " high_per_period"}, 32'(win_hi[k]), 32'(pre[k] * win_duty[k]));
`endif
      end
      win_len[k]    = 0;
      win_hi[k]     = 0;
      win_duty[k]   = m_duty[k];
      win_valid[k]  = (m_n[k] > 1);
      win_active[k] = 1'b1;
    end
    if (!en) begin
      win_active[k] = 1'b0;
      win_valid[k]  = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle_then_enable(input logic [W-1:0] a);
    en  = 1'b0;
    amp = a;
    run_cycles(6);
    en = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_n[k]        = 0;
      m_duty[k]     = 0;
      win_active[k] = 1'b0;
      win_valid[k]  = 1'b0;
      for (int i = 0; i <= Dt; i++) rh[k][i] = 1'b0;
    end

    // Reset held with enable high: everything stays low.
    reset_n = 1'b0;
    en      = 1'b1;
    amp     = W'(5);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset pwm_out", 32'(bus_p1.pwm_out | bus_p3.pwm_out), 32'd0);
    check_eq("reset period_start", 32'(bus_p1.period_start | bus_p3.period_start), 32'd0);
    check_eq("reset duty_active", 32'(bus_p1.duty_active | bus_p3.duty_active), 32'd0);
`ifdef DDS_PWM_COMPLEMENT_EN
    check_eq("reset pwm_l", 32'(bus_p1.pwm_l | bus_p3.pwm_l), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Steady duty 5.
    run_cycles(100);
    // Duty 0: never high.
    idle_then_enable(W'(0));
    run_cycles(100);
    // Full scale across at least three wraps of the slow instance.
    idle_then_enable(W'(15));
    run_cycles(150);
    // Mid-period write 3 -> 12 at cnt 6.
    idle_then_enable(W'(3));
    run_cycles(6);
    amp = W'(12);
    run_cycles(60);
    // Disable mid-period.
    run_cycles(7);
    en = 1'b0;
    run_cycles(6);

    // Random segments with occasional mid-period writes.
    for (int s = 0; s < 20; s++) begin
      idle_then_enable(W'($urandom_range(0, 15)));
      for (int c = 0, len = $urandom_range(20, 120); c < len; c++) begin
        if ($urandom_range(0, 7) == 0) amp = W'($urandom_range(0, 15));
        cycle();
      end
    end
    en = 1'b0;
    run_cycles(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
